// File: rtl/gray_input_conditioner_pkg.sv
// Shared types and defaults for the Gray/button input conditioner.
package gray_input_pkg;

    typedef logic [3:0] gray_t;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 270000;
    localparam int SYNC_STAGES_DEF     = 2;

    // Number of bits that differ between two Gray codes.
    function automatic logic [2:0] gray_dist(input gray_t a, input gray_t b);
        gray_t d;
        logic [2:0] n;
        d = a ^ b;
        n = 3'd0;
        for (int i = 0; i < 4; i++) n = n + {2'b00, d[i]};
        return n;
    endfunction

endpackage

// File: rtl/gray_input_conditioner_if.sv
// Board-side bundle: raw switches/button in, conditioned code/strobes out.
interface gray_input_if;
    import gray_input_pkg::*;

    gray_t codigo_gray_raw_pi;
    logic  boton_raw_pi;
    gray_t codigo_gray_po;
    logic  gray_valido_po;
    logic  boton_nivel_po;
    logic  boton_pulso_po;
    logic  gray_error_po;

    modport slave (
        input  codigo_gray_raw_pi, boton_raw_pi,
        output codigo_gray_po, gray_valido_po, boton_nivel_po,
               boton_pulso_po, gray_error_po
    );

    modport master (
        output codigo_gray_raw_pi, boton_raw_pi,
        input  codigo_gray_po, gray_valido_po, boton_nivel_po,
               boton_pulso_po, gray_error_po
    );
endinterface

// File: rtl/gray_input_conditioner_sync_ff.sv
// Multi-stage flop synchroniser, WIDTH bits wide, STAGES deep.
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/gray_input_conditioner.sv
// Synchronises and debounces the Gray switches and reset button.
// Optional GRAY_ILLEGAL_CHECK_EN flags multi-bit jumps at commit time.
module gray_input_conditioner
    import gray_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic          clk_pi,
    input  logic          rst_pi,
    gray_input_if.slave   bus
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(DEBOUNCE_CYCLES - 2);

    gray_t   gray_sync;
    logic    btn_sync;
    gray_t   cand;
    logic [CW-1:0] cnt;
    gray_t   gray_q;
    logic    valido_q;
    logic    gray_commit;

    btn_state_t    bstate;
    logic [CW-1:0] bcnt;
    logic          pulso_q;

    sync_ff #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sync_gray (
        .clk   (clk_pi),
        .rst_n (rst_pi),
        .d     (bus.codigo_gray_raw_pi),
        .q     (gray_sync)
    );

    sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_btn (
        .clk   (clk_pi),
        .rst_n (rst_pi),
        .d     (bus.boton_raw_pi),
        .q     (btn_sync)
    );

    // The edge that loads cand is the first stable sample, so the commit
    // happens on the DEBOUNCE_CYCLES-th consecutive sample (cnt moving to LAST).
    assign gray_commit = (gray_sync == cand) && (cnt == CNT_PRE) && (cand != gray_q);

    always_ff @(posedge clk_pi or negedge rst_pi) begin
        if (!rst_pi) begin
            cand     <= '0;
            cnt      <= '0;
            gray_q   <= '0;
            valido_q <= 1'b0;
        end else begin
            valido_q <= 1'b0;
            if (gray_sync != cand) begin
                cand <= gray_sync;
                cnt  <= '0;
            end else begin
                if (cnt < CNT_LAST) cnt <= cnt + 1'b1;
                if (gray_commit) begin
                    gray_q   <= cand;
                    valido_q <= 1'b1;
                end
            end
        end
    end

`ifdef GRAY_ILLEGAL_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_pi or negedge rst_pi) begin
        if (!rst_pi) begin
            err_q <= 1'b0;
        end else if (gray_commit && (gray_dist(cand, gray_q) > 3'd1)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.gray_error_po = err_q;
`else
    assign bus.gray_error_po = 1'b0;
`endif

    // Button: same stable-sample count as the Gray path, pulse only on press.
    always_ff @(posedge clk_pi or negedge rst_pi) begin
        if (!rst_pi) begin
            bstate  <= LOW;
            bcnt    <= '0;
            pulso_q <= 1'b0;
        end else begin
            pulso_q <= 1'b0;
            case (bstate)
                LOW: begin
                    if (btn_sync) begin
                        bstate <= WAIT_HIGH;
                        bcnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!btn_sync) begin
                        bstate <= LOW;
                    end else if (bcnt == CNT_PRE) begin
                        bstate  <= HIGH;
                        pulso_q <= 1'b1;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (!btn_sync) begin
                        bstate <= WAIT_LOW;
                        bcnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (btn_sync) begin
                        bstate <= HIGH;
                    end else if (bcnt == CNT_PRE) begin
                        bstate <= LOW;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                default: bstate <= LOW;
            endcase
        end
    end

    assign bus.codigo_gray_po = gray_q;
    assign bus.gray_valido_po = valido_q;
    assign bus.boton_nivel_po = (bstate == HIGH) || (bstate == WAIT_LOW);
    assign bus.boton_pulso_po = pulso_q;

endmodule
